// File: rtl/seq_ax_argmax_if.sv
// Score-in / class-out handshake bundle for the streaming approximate argmax.
// The master drives scores and accepts results; the slave is the argmax block.
interface seq_ax_argmax_if #(
    parameter int SCORE_W = 16,
    parameter int IDX_W   = 2
);
    logic               in_valid;
    logic               in_ready;
    logic [SCORE_W-1:0] in_score;
    logic               in_last;
    logic               out_valid;
    logic               out_ready;
    logic [IDX_W-1:0]   out_idx;
    logic [SCORE_W-1:0] out_score;
    logic               out_err;

    modport master (
        output in_valid, in_score, in_last, out_ready,
        input  in_ready, out_valid, out_idx, out_score, out_err
    );

    modport slave (
        input  in_valid, in_score, in_last, out_ready,
        output in_ready, out_valid, out_idx, out_score, out_err
    );
endinterface

// File: rtl/seq_ax_argmax.sv
// Streaming argmax over NUM_CLASSES scores per frame, comparing only the
// CMP_MASK bits; ties go to the later class. One result register, in-order.
module seq_ax_argmax #(
    parameter int                 NUM_CLASSES = 3,
    parameter int                 SCORE_W     = 16,
    parameter int                 IDX_W       = $clog2(NUM_CLASSES),
    parameter logic [SCORE_W-1:0] CMP_MASK    = {SCORE_W{1'b1}}
) (
    input logic            clk,
    input logic            rst,
    seq_ax_argmax_if.slave bus
);
    typedef enum logic {ACCUM, HOLD} state_t;

    typedef struct packed {
        logic [IDX_W-1:0]   idx;
        logic [SCORE_W-1:0] score;
        logic               err;
    } res_t;

    localparam logic [IDX_W-1:0] LAST = IDX_W'(NUM_CLASSES - 1);

    state_t             state, state_nxt;
    logic [IDX_W-1:0]   cnt;
    logic [IDX_W-1:0]   best_idx;
    logic [SCORE_W-1:0] best_score;
    res_t               res, res_nxt;
    logic               vld, rdy, accept, closing, take_new;

    // Output decode: a held result only blocks input while it is not being taken.
    always_comb begin
        vld = (state == HOLD);
        rdy = !rst && (!vld || bus.out_ready);
    end

    assign bus.in_ready  = rdy;
    assign bus.out_valid = vld;
    assign bus.out_idx   = res.idx;
    assign bus.out_score = res.score;
    assign bus.out_err   = res.err;

    assign accept   = bus.in_valid && rdy;
    assign closing  = accept && (bus.in_last || cnt == LAST);
    assign take_new = (cnt == '0) ||
                      ((bus.in_score & CMP_MASK) >= (best_score & CMP_MASK));

    // Winner including the current score; a closing score that is not in_last
    // can only happen at cnt == LAST, so that case is always a long frame.
    always_comb begin
        res_nxt.idx   = take_new ? cnt : best_idx;
        res_nxt.score = take_new ? bus.in_score : best_score;
        res_nxt.err   = bus.in_last ? (cnt != LAST) : 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) state <= ACCUM;
        else     state <= state_nxt;
    end

    // Closing wins over release so a single-score frame taken during HOLD re-holds.
    always_comb begin
        state_nxt = state;
        if (closing)                          state_nxt = HOLD;
        else if (state == HOLD && bus.out_ready) state_nxt = ACCUM;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt        <= '0;
            best_idx   <= '0;
            best_score <= '0;
            res        <= '0;
        end else begin
            if (accept) begin
                cnt        <= closing ? '0 : cnt + 1'b1;
                best_idx   <= res_nxt.idx;
                best_score <= res_nxt.score;
            end
            if (closing)
                res <= res_nxt;
            else if (vld && bus.out_ready)
                res.err <= 1'b0;
        end
    end
endmodule
